// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and word-length limits.
// The receiver imports this package as well.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DATA_BITS = 5;

  // Any out-of-range request is pulled to the nearest legal word length.
  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    logic [3:0] len;
    len = req;
    if (req < 4'(MIN_DATA_BITS)) len = 4'(MIN_DATA_BITS);
    else if (req > max_bits)     len = max_bits;
    return len;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: flags the baud_tick that closes one serial bit time.
// Also used by the receiver's half-bit sampler.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic bclk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic clear,
  output logic bit_end
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  // A tick arriving together with clear is dropped so timing restarts from zero.
  always_comb begin
    bit_end    = baud_tick && !clear && (tick_cnt_q == LAST);
    tick_cnt_d = tick_cnt_q;
    if (clear)         tick_cnt_d = '0;
    else if (bit_end)  tick_cnt_d = '0;
    else if (baud_tick) tick_cnt_d = tick_cnt_q + 1'b1;
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: runtime word length, optional parity, one or two stop bits,
// valid/ready load handshake and a registered txd line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int   DATA_BITS_MAX = 8,
  parameter int   OVERSAMPLE    = 16,
  parameter logic IDLE_LEVEL    = 1'b1
) (
  input  logic                     bclk,
  input  logic                     rst_n,
  input  logic                     baud_tick,
  input  logic [DATA_BITS_MAX-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_two_stop,
  output logic                     txd,
  output logic                     busy,
  output logic                     txd_done
);

  localparam logic [3:0] MAXB = 4'(DATA_BITS_MAX);

  uart_state_e              state_q, state_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic                     txd_q, txd_d;
  logic                     done_q, done_d;
  logic [DATA_BITS_MAX-1:0] shreg_q, shreg_d;
  logic [3:0]               nbits_q, nbits_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     two_stop_q, two_stop_d;
  logic                     bit_end;

  function automatic logic word_parity(input logic [DATA_BITS_MAX-1:0] w, input logic [3:0] len);
    logic p;
    p = 1'b0;
    for (int i = 0; i < DATA_BITS_MAX; i++) begin
      if (i < int'(len)) p = p ^ w[i];
    end
    return p;
  endfunction

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .bclk      (bclk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .clear     (state_q == IDLE),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: if (tx_valid) begin
        shreg_d    = tx_data;
        nbits_d    = clamp_bits(cfg_data_bits, MAXB);
        par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
        par_bit_d  = word_parity(tx_data, nbits_d) ^ (cfg_parity == PAR_ODD);
        two_stop_d = cfg_two_stop;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        state_d    = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shreg_d = shreg_q >> 1;
        if (bit_cnt_q == nbits_q - 4'd1) begin
          bit_cnt_d = '0;
          state_d   = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        if (two_stop_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          stop_cnt_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered, so it is derived from where the frame will be next cycle.
    unique case (state_d)
      START:   txd_d = ~IDLE_LEVEL;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= IDLE_LEVEL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  // Word and frame config are only consumed outside IDLE, so they carry no reset.
  always_ff @(posedge bclk) begin
    shreg_q    <= shreg_d;
    nbits_q    <= nbits_d;
    par_en_q   <= par_en_d;
    par_bit_q  <= par_bit_d;
    two_stop_q <= two_stop_d;
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign txd      = txd_q;
  assign txd_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of single frames plus back-to-back, stall,
// mid-frame config change and mid-frame reset sequences.
module tb_uart_tx_ctrl;

  logic       bclk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] cfg_data_bits;
  logic [1:0] cfg_parity;
  logic       cfg_two_stop;
  logic       txd;
  logic       busy;
  logic       txd_done;

  int checks = 0;
  int errors = 0;

  logic lt [0:511];
  logic ld [0:511];
  logic lr [0:511];
  logic lb [0:511];

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  bits;
    logic [1:0]  par;
    logic        two;
    int          len;
    logic [0:11] exp;
  } vec_t;

  vec_t vecs [6];

  uart_tx_ctrl #(.DATA_BITS_MAX(8), .OVERSAMPLE(16), .IDLE_LEVEL(1'b1)) dut (
    .bclk          (bclk),
    .rst_n         (rst_n),
    .baud_tick     (baud_tick),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_two_stop  (cfg_two_stop),
    .txd           (txd),
    .busy          (busy),
    .txd_done      (txd_done)
  );

  always #5 bclk = ~bclk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [3:0] nb,
                             input logic [1:0] p, input logic two);
    int w;
    w = 0;
    @(negedge bclk);
    while (!tx_ready && w < 400) begin
      @(negedge bclk);
      w++;
    end
    chk1("ready_before_accept", tx_ready, 1'b1);
    tx_data       = d;
    cfg_data_bits = nb;
    cfg_parity    = p;
    cfg_two_stop  = two;
    tx_valid      = 1'b1;
    @(posedge bclk);
    #1 tx_valid = 1'b0;
  endtask

  // Cycle 0 is the first cycle after the accepting edge.
  task automatic record(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge bclk);
      lt[c] = txd;
      ld[c] = txd_done;
      lr[c] = tx_ready;
      lb[c] = busy;
    end
  endtask

  task automatic done_scan(input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int c = 0; c < n; c++) begin
      if (ld[c]) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
  endtask

  task automatic check_frame(input string name, input int len, input logic [0:11] exp, input int n);
    int first, cnt;
    done_scan(n, first, cnt);
    chki({name, "_done_cycle"}, first, 16 * len);
    chki({name, "_done_count"}, cnt, 1);
    chk1({name, "_busy_first"}, lb[0], 1'b1);
    chk1({name, "_ready_first"}, lr[0], 1'b0);
    for (int k = 0; k < len; k++)
      chk1($sformatf("%s_bit%0d", name, k), lt[16 * k + 8], exp[k]);
    chk1({name, "_ready_end"}, lr[16 * len], 1'b1);
    chk1({name, "_busy_end"}, lb[16 * len], 1'b0);
  endtask

  initial begin
    int first, cnt, w, ones;
    int dcyc [3];
    logic [7:0] b55;

    vecs[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 10, 12'b0101_0010_1111};
    vecs[1] = '{8'h41, 4'd7,  2'b01, 1'b1, 11, 12'b0100_0001_0111};
    vecs[2] = '{8'h43, 4'd7,  2'b01, 1'b1, 11, 12'b0110_0001_1111};
    vecs[3] = '{8'h1F, 4'd3,  2'b10, 1'b0,  8, 12'b0111_1101_1111};
    vecs[4] = '{8'hF0, 4'd15, 2'b01, 1'b0, 11, 12'b0000_0111_1011};
    vecs[5] = '{8'hEA, 4'd6,  2'b11, 1'b1,  9, 12'b0010_1011_1111};

    rst_n = 1'b0; baud_tick = 1'b1; tx_data = '0; tx_valid = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    repeat (3) @(negedge bclk);
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_ready", tx_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", txd_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge bclk);
    chk1("idle_txd", txd, 1'b1);

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].data, vecs[i].bits, vecs[i].par, vecs[i].two);
      record(200);
      check_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp, 200);
    end

    // Baud ticks withheld for 100 cycles mid-frame: the frame stretches by exactly that.
    start_frame(8'h0D, 4'd8, 2'b00, 1'b0);
    fork
      record(300);
      begin
        repeat (40) @(negedge bclk);
        baud_tick = 1'b0;
        repeat (100) @(negedge bclk);
        baud_tick = 1'b1;
      end
    join
    done_scan(300, first, cnt);
    chki("stall_done_cycle", first, 260);
    chki("stall_done_count", cnt, 1);
    chk1("stall_hold_bit", lt[138], 1'b0);
    chk1("stall_resume_bit2", lt[147], 1'b0);
    chk1("stall_resume_bit3", lt[148], 1'b1);

    // Back-to-back with tx_valid held high.
    @(negedge bclk);
    tx_data = 8'h00; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    tx_valid = 1'b1;
    @(posedge bclk);
    fork
      record(500);
      begin
        #1 tx_data = 8'hFF;
        for (int f = 0; f < 2; f++) begin
          w = 0;
          @(negedge bclk);
          while (!tx_ready && w < 400) begin
            @(negedge bclk);
            w++;
          end
          @(posedge bclk);
          #1 tx_data = 8'h55;
        end
        tx_valid = 1'b0;
      end
    join
    cnt = 0;
    for (int c = 0; c < 500; c++) begin
      if (ld[c]) begin
        if (cnt < 3) dcyc[cnt] = c;
        cnt++;
      end
    end
    chki("b2b_done_count", cnt, 3);
    if (cnt >= 3) begin
      chki("b2b_done0", dcyc[0], 160);
      chki("b2b_done1", dcyc[1], 321);
      chki("b2b_done2", dcyc[2], 482);
    end
    chk1("b2b_gap_idle", lt[160], 1'b1);
    chk1("b2b_next_start", lt[161], 1'b0);
    b55  = 8'h55;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      if (lt[16 * (k + 1) + 8] !== 1'b0) ones++;
      if (lt[161 + 16 * (k + 1) + 8] !== 1'b1) ones++;
      if (lt[322 + 16 * (k + 1) + 8] !== b55[k]) ones++;
    end
    chki("b2b_data_bits_wrong", ones, 0);
    chk1("b2b_last_stop", lt[322 + 16 * 9 + 8], 1'b1);

    // Config changes right after accept must not affect the frame in flight.
    start_frame(8'h81, 4'd8, 2'b00, 1'b0);
    cfg_parity = 2'b01;
    cfg_two_stop = 1'b1;
    record(200);
    check_frame("cfg_old", 10, 12'b0100_0000_1111, 200);
    start_frame(8'h81, 4'd8, 2'b01, 1'b1);
    record(220);
    check_frame("cfg_new", 12, 12'b0100_0000_1011, 220);

    // Reset during data bit 4 of an all-zero word.
    start_frame(8'h00, 4'd8, 2'b00, 1'b0);
    repeat (89) @(negedge bclk);
    chk1("mid_txd_before", txd, 1'b0);
    chk1("mid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_txd", txd, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ready", tx_ready, 1'b1);
    chk1("mid_rst_done", txd_done, 1'b0);
    repeat (2) @(negedge bclk);
    rst_n = 1'b1;
    record(200);
    done_scan(200, first, cnt);
    chki("post_rst_done_count", cnt, 0);
    ones = 0;
    for (int c = 0; c < 200; c++) if (lt[c] !== 1'b1) ones++;
    chki("post_rst_txd_low_cycles", ones, 0);
    start_frame(8'hA5, 4'd8, 2'b00, 1'b0);
    record(200);
    check_frame("post_rst_frame", 10, 12'b0101_0010_1111, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
